arbitro_mem_datos: RTL and testbench

// - Shares the byte-organised data memory (MemDatos-style, big-endian) between two requesters: 0 = CPU, 1 = DMA.
// - Converts each 32-bit word load/store into four sequenced byte beats on a single byte-wide memory port.
// - Sits between the CPU/DMA load-store paths and the data RAM.
// - Arbitration is round-robin.

---
 rtl/arbitro_mem_datos.sv | 146 ++++++++++++++
 tb/tb_arbitro_mem_datos.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_mem_datos.sv
// arbitro_mem_datos: round-robin arbiter sharing a byte-wide, big-endian data
// RAM between the CPU (port 0) and the DMA (port 1). Each 32-bit word access
// becomes four MSB-first byte beats on the memory port, followed by a
// one-cycle ack.
// Optional feature macro: ALINEA_CHK_EN (misaligned accesses are rejected
// with an err pulse instead of being serviced).
module arbitro_mem_datos #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              esc0,
  input  logic              esc1,
  input  logic [31:0]       dir0,
  input  logic [31:0]       dir1,
  input  logic [31:0]       datoe0,
  input  logic [31:0]       datoe1,
  output logic              ack0,
  output logic              ack1,
  output logic [31:0]       datos0,
  output logic [31:0]       datos1,
  output logic [ADDR_W-1:0] mem_dir,
  output logic [7:0]        mem_datoe,
  output logic              mem_esc,
  output logic              mem_leer,
  input  logic [7:0]        mem_datos
`ifdef ALINEA_CHK_EN
  ,
  output logic              err
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic              ptr;
  logic              gnt;
  logic [1:0]        beat;
  logic              esc_r;
  logic [ADDR_W-1:0] dir_r;
  logic [31:0]       datoe_r;
  logic              gsel;
  logic [ADDR_W-1:0] dsel;
  logic              unused_hi;
`ifdef ALINEA_CHK_EN
  logic              misal;
`endif

  // Address bits above the RAM size are deliberately ignored.
  assign unused_hi = ^{dir0[31:ADDR_W], dir1[31:ADDR_W]};

  // Grant selection: a lone requester wins, contention goes to ptr.
  always_comb begin
    gsel = ptr;
    if (req0 && !req1) gsel = 1'b0;
    else if (req1 && !req0) gsel = 1'b1;
    dsel = gsel ? dir1[ADDR_W-1:0] : dir0[ADDR_W-1:0];
  end

  // Control FSM, request latching and load-byte capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      gnt     <= 1'b0;
      beat    <= '0;
      esc_r   <= 1'b0;
      dir_r   <= '0;
      datoe_r <= '0;
      datos0  <= '0;
      datos1  <= '0;
`ifdef ALINEA_CHK_EN
      misal   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt     <= gsel;
            esc_r   <= gsel ? esc1 : esc0;
            dir_r   <= dsel;
            datoe_r <= gsel ? datoe1 : datoe0;
            beat    <= '0;
`ifdef ALINEA_CHK_EN
            if (dsel[1:0] != 2'b00) begin
              misal <= 1'b1;
              state <= DONE;
            end else begin
              misal <= 1'b0;
              state <= XFER;
            end
`else
            state   <= XFER;
`endif
          end
        end
        XFER: begin
          // {~beat,3'b000} == 8*(3-beat): byte 0 lands in bits 31:24.
          if (!esc_r) begin
            if (gnt) datos1[{~beat, 3'b000} +: 8] <= mem_datos;
            else     datos0[{~beat, 3'b000} +: 8] <= mem_datos;
          end
          beat <= beat + 2'd1;
          if (beat == 2'd3) state <= DONE;
        end
        DONE: begin
          ptr   <= ~gnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory port and handshake outputs decoded from the current state.
  always_comb begin
    mem_dir   = '0;
    mem_datoe = '0;
    mem_esc   = 1'b0;
    mem_leer  = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    if (state == XFER) begin
      mem_dir  = dir_r + ADDR_W'(beat);
      mem_esc  = esc_r;
      mem_leer = ~esc_r;
      if (esc_r) mem_datoe = datoe_r[{~beat, 3'b000} +: 8];
    end
    if (state == DONE) begin
      ack0 = ~gnt;
      ack1 = gnt;
    end
  end

`ifdef ALINEA_CHK_EN
  // Misalignment error accompanies the ack of a rejected access.
  always_comb begin
    err = (state == DONE) && misal;
  end
`endif

endmodule

// File: tb/tb_arbitro_mem_datos.sv
// Self-checking bench for arbitro_mem_datos: byte RAM model, per-scenario
// tasks, and an ack-driven scoreboard holding expected port/data per access.
module tb_arbitro_mem_datos;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, esc0, esc1;
  logic [31:0] dir0, dir1, datoe0, datoe1;
  logic        ack0, ack1;
  logic [31:0] datos0, datos1;
  logic [7:0]  mem_dir, mem_datoe, mem_datos;
  logic        mem_esc, mem_leer;
`ifdef ALINEA_CHK_EN
  logic        err;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit          port;
    bit          load;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  logic [31:0] exp_d0, exp_d1;
  bit          prev_ack;
  bit          leer_seen;

  logic [7:0]  ram [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_a, pre_d;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arbitro_mem_datos #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .esc0(esc0), .esc1(esc1),
    .dir0(dir0), .dir1(dir1), .datoe0(datoe0), .datoe1(datoe1),
    .ack0(ack0), .ack1(ack1), .datos0(datos0), .datos1(datos1),
    .mem_dir(mem_dir), .mem_datoe(mem_datoe), .mem_esc(mem_esc),
    .mem_leer(mem_leer), .mem_datos(mem_datos)
`ifdef ALINEA_CHK_EN
    , .err(err)
`endif
  );

  // RAM model: combinational read, synchronous byte write.
  assign mem_datos = mem_leer ? ram[mem_dir] : 8'h00;
  always @(posedge clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (mem_esc) ram[mem_dir] <= mem_datoe;
  end

  // Scoreboard monitor: pops one expectation per ack.
  always @(negedge clk) begin
    if (rst) begin
      exp_d0   = '0;
      exp_d1   = '0;
      prev_ack = 1'b0;
    end else begin
      total++;
      if (mem_esc && mem_leer) begin
        bad++;
        $display("FAIL strobes: mem_esc=%0b mem_leer=%0b required not both 1", mem_esc, mem_leer);
      end
      if (mem_leer) leer_seen = 1'b1;
`ifdef ALINEA_CHK_EN
      total++;
      if (err && !(ack0 || ack1)) begin
        bad++;
        $display("FAIL err_alone: err=1 without ack");
      end
`endif
      if (ack0 || ack1) begin
        total++;
        if (prev_ack) begin
          bad++;
          $display("FAIL ack_width: ack high two cycles in a row at cyc %0d", cyc);
        end
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ack: ack0=%0b ack1=%0b with empty scoreboard", ack0, ack1);
        end else begin
          e = sbq.pop_front();
          total++;
          if ((ack0 && ack1) || (ack1 !== e.port)) begin
            bad++;
            $display("FAIL ack_port: ack0=%0b ack1=%0b required port %0d", ack0, ack1, e.port);
          end
          if (e.load && !e.port) exp_d0 = e.data;
          if (e.load && e.port)  exp_d1 = e.data;
          total++;
          if (datos0 !== exp_d0) begin
            bad++;
            $display("FAIL datos0: got %h required %h", datos0, exp_d0);
          end
          total++;
          if (datos1 !== exp_d1) begin
            bad++;
            $display("FAIL datos1: got %h required %h", datos1, exp_d1);
          end
`ifdef ALINEA_CHK_EN
          total++;
          if (err !== e.err) begin
            bad++;
            $display("FAIL err: got %0b required %0b", err, e.err);
          end
`endif
        end
      end
      prev_ack = ack0 || ack1;
    end
  end

  task automatic preset(input logic [7:0] a, input logic [7:0] d);
    pre_a  = a;
    pre_d  = d;
    pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  function automatic exp_t mk(input bit port, input bit esc, input logic [31:0] dir);
    exp_t r;
    logic [7:0] a;
    a      = dir[7:0];
    r.port = port;
    r.load = !esc;
    r.err  = 1'b0;
    r.data = {ram[a], ram[a + 8'd1], ram[a + 8'd2], ram[a + 8'd3]};
`ifdef ALINEA_CHK_EN
    if (dir[1:0] != 2'b00) begin
      r.load = 1'b0;
      r.err  = 1'b1;
    end
`endif
    return r;
  endfunction

  task automatic drive(input bit port, input bit r, input bit esc,
                       input logic [31:0] dir, input logic [31:0] d);
    if (port) begin req1 = r; esc1 = esc; dir1 = dir; datoe1 = d; end
    else      begin req0 = r; esc0 = esc; dir0 = dir; datoe0 = d; end
  endtask

  // Full requester handshake; lat = edges from req rise to ack visible.
  task automatic do_access(input bit port, input bit esc, input logic [31:0] dir,
                           input logic [31:0] d, output int lat);
    sbq.push_back(mk(port, esc, dir));
    @(posedge clk); #1;
    drive(port, 1'b1, esc, dir, d);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(port ? ack1 : ack0) && lat < 50);
    if (lat >= 50) begin
      bad++;
      $display("FAIL ack_timeout: port %0d no ack within 50 cycles", port);
    end
    @(posedge clk); #1;
    drive(port, 1'b0, esc, dir, d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({ack0, ack1, mem_esc, mem_leer} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl: ack0/ack1/esc/leer=%b required 0000", {ack0, ack1, mem_esc, mem_leer});
    end
    total++;
    if ({datos0, datos1} !== 64'h0) begin
      bad++;
      $display("FAIL reset_datos: got %h %h required 0 0", datos0, datos1);
    end
    total++;
    if ({mem_dir, mem_datoe} !== 16'h0) begin
      bad++;
      $display("FAIL reset_mem: dir=%h datoe=%h required 00 00", mem_dir, mem_datoe);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    int lat;
    do_access(0, 1, 32'h10, 32'hDEADBEEF, lat);
    total++;
    if ({ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13]} !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL store_bytes: got %h %h %h %h required DE AD BE EF",
               ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13]);
    end
    total++;
    if (lat !== 5) begin
      bad++;
      $display("FAIL store_latency: got %0d required 5", lat);
    end
    do_access(0, 0, 32'h10, 32'h0, lat);
    total++;
    if (lat !== 5) begin
      bad++;
      $display("FAIL load_latency: got %0d required 5", lat);
    end
    total++;
    if (datos0 !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL load_data: got %h required DEADBEEF", datos0);
    end
  endtask

  task automatic test_contention();
    bit ord[4];
    int ackc[4];
    int n = 0;
    int t = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    preset(8'h40, 8'h01); preset(8'h41, 8'h02); preset(8'h42, 8'h03); preset(8'h43, 8'h04);
    preset(8'h80, 8'hA1); preset(8'h81, 8'hA2); preset(8'h82, 8'hA3); preset(8'h83, 8'hA4);
    for (int unsigned i = 0; i < 2; i++) begin
      sbq.push_back(mk(0, 0, 32'h40));
      sbq.push_back(mk(1, 0, 32'h80));
    end
    drive(0, 1, 0, 32'h40, '0);
    drive(1, 1, 0, 32'h80, '0);
    while (n < 4 && t < 100) begin
      @(posedge clk); #1;
      t++;
      if (ack0 || ack1) begin
        ord[n]  = ack1;
        ackc[n] = cyc;
        n++;
      end
    end
    @(posedge clk); #1;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    total++;
    if (n !== 4) begin
      bad++;
      $display("FAIL contention_count: got %0d acks required 4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (ord[i] !== bit'(i % 2)) begin
          bad++;
          $display("FAIL contention_order: grant %0d went to port %0d required %0d", i, ord[i], i % 2);
        end
      end
      for (int i = 1; i < 4; i++) begin
        total++;
        if (ackc[i] - ackc[i-1] !== 6) begin
          bad++;
          $display("FAIL b2b_period: got %0d cycles required 6", ackc[i] - ackc[i-1]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int lat;
    do_access(1, 1, 32'hABCD00FE, 32'h11223344, lat);
    total++;
    if ({ram[8'hFE], ram[8'hFF], ram[8'h00], ram[8'h01]} !== 32'h11223344) begin
      bad++;
      $display("FAIL wrap_bytes: got %h %h %h %h required 11 22 33 44",
               ram[8'hFE], ram[8'hFF], ram[8'h00], ram[8'h01]);
    end
  endtask

  task automatic test_drop();
    int acks = 0;
    for (int unsigned i = 0; i < 4; i++) preset(8'(8'h30 + i), 8'h00);
    sbq.push_back(mk(0, 1, 32'h30));
    drive(0, 1, 1, 32'h30, 32'hCAFEF00D);
    repeat (3) @(posedge clk);
    #1;
    drive(0, 0, 1, 32'h30, 32'hCAFEF00D);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ack0) acks++;
    end
    total++;
    if (acks !== 1) begin
      bad++;
      $display("FAIL drop_ack: got %0d acks required 1", acks);
    end
    total++;
    if ({ram[8'h30], ram[8'h31], ram[8'h32], ram[8'h33]} !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL drop_bytes: got %h %h %h %h required CA FE F0 0D",
               ram[8'h30], ram[8'h31], ram[8'h32], ram[8'h33]);
    end
  endtask

  task automatic test_rst_mid();
    int acks = 0;
    for (int unsigned i = 0; i < 4; i++) preset(8'(8'h20 + i), 8'h5A);
    drive(0, 1, 1, 32'h20, 32'h01020304);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if ({ack0, ack1, mem_esc, mem_leer, mem_dir, mem_datoe} !== 20'h0) begin
      bad++;
      $display("FAIL rst_mid_outputs: esc=%0b leer=%0b dir=%h datoe=%h ack=%0b%0b required all 0",
               mem_esc, mem_leer, mem_dir, mem_datoe, ack0, ack1);
    end
    drive(0, 0, 0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack0 || ack1) acks++;
    end
    total++;
    if (acks !== 0) begin
      bad++;
      $display("FAIL rst_mid_ack: got %0d acks required 0", acks);
    end
    total++;
    if ({ram[8'h20], ram[8'h21], ram[8'h22], ram[8'h23]} !== 32'h01025A5A) begin
      bad++;
      $display("FAIL rst_mid_bytes: got %h %h %h %h required 01 02 5A 5A",
               ram[8'h20], ram[8'h21], ram[8'h22], ram[8'h23]);
    end
  endtask

  task automatic test_misaligned();
    int lat;
    preset(8'h03, 8'h9A); preset(8'h04, 8'hBC); preset(8'h05, 8'hDE); preset(8'h06, 8'hF0);
    do_access(0, 0, 32'h10, 32'h0, lat);
    leer_seen = 1'b0;
    do_access(0, 0, 32'h03, 32'h0, lat);
`ifdef ALINEA_CHK_EN
    total++;
    if (lat !== 1) begin
      bad++;
      $display("FAIL misal_latency: got %0d required 1", lat);
    end
    total++;
    if (leer_seen !== 1'b0) begin
      bad++;
      $display("FAIL misal_leer: mem_leer seen=%0b required 0", leer_seen);
    end
    total++;
    if (datos0 !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL misal_datos: got %h required DEADBEEF", datos0);
    end
`else
    total++;
    if (lat !== 5) begin
      bad++;
      $display("FAIL misal_latency: got %0d required 5", lat);
    end
    total++;
    if (datos0 !== 32'h9ABCDEF0) begin
      bad++;
      $display("FAIL misal_datos: got %h required 9ABCDEF0", datos0);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_contention();
    test_wrap();
    test_drop();
    test_rst_mid();
    test_misaligned();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (sbq.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_left: %0d expected acks never seen, required 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
